// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: gates the RLE compressor, turns its address-count
// strobe into circular SRAM writes, and tracks pre/post-trigger windows.
module la_capture_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic              RLE_MODE,
  input  logic              FORCE_TRIG,
  input  logic [7:0]        TRIG_MASK,
  input  logic [7:0]        TRIG_VALUE,
  input  logic [ADDR_W-1:0] PRE_CNT,
  input  logic [ADDR_W-1:0] POST_CNT,
  input  logic [7:0]        LA_DATA,
  input  logic              ADDR_CNT_EN,
  output logic              CAP_CLK_EN,
  output logic              CAP_RLE_EN,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              BUSY,
  output logic              TRIGGERED,
  output logic              DONE
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_FLUSH, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] pre_q, pre_d, post_q, post_d;
  logic [7:0]        mask_q, mask_d, val_q, val_d;
  logic              rle_q, rle_d, trig_q, trig_d;
  logic              clk_en_q, clk_en_d, rle_en_q, rle_en_d, busy_q, busy_d, done_q, done_d;
  logic              capturing, we, match, launch, abort, trig_hit;

  assign capturing = (state_q == S_FILL) || (state_q == S_ARMED) ||
                     (state_q == S_POST) || (state_q == S_FLUSH);
  assign we        = ADDR_CNT_EN && capturing;
  assign match     = (((LA_DATA ^ val_q) & mask_q) == 8'h00) && (mask_q != 8'h00);
  assign launch    = START && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign abort     = ABORT && capturing;
  assign trig_hit  = (state_q == S_ARMED) && (match || FORCE_TRIG) && !abort;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (launch) state_d = S_FILL;
      S_FILL:  if (pre_q == '0 || (we && cnt_q + ONE == pre_q)) state_d = S_ARMED;
      S_ARMED: if (trig_hit) begin
        if (post_q != '0) state_d = S_POST;
        else              state_d = rle_q ? S_FLUSH : S_DONE;
      end
      S_POST:  if (we && cnt_q + ONE == post_q) state_d = rle_q ? S_FLUSH : S_DONE;
      S_FLUSH: if (we) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Write/post counter, circular address and trigger bookkeeping; config latched only at launch.
  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    trig_addr_d = trig_addr_q;
    trig_d      = trig_q;
    pre_d       = pre_q;
    post_d      = post_q;
    mask_d      = mask_q;
    val_d       = val_q;
    rle_d       = rle_q;
    if (we && !abort) begin
      addr_d = addr_q + ONE;
      if (state_q == S_FILL || state_q == S_POST) cnt_d = cnt_q + ONE;
    end
    if (trig_hit) begin
      trig_addr_d = addr_q;
      trig_d      = 1'b1;
      cnt_d       = '0;
    end
    if (abort) trig_d = 1'b0;
    if (launch) begin
      cnt_d  = '0;
      addr_d = '0;
      trig_d = 1'b0;
      pre_d  = PRE_CNT;
      post_d = POST_CNT;
      mask_d = TRIG_MASK;
      val_d  = TRIG_VALUE;
      rle_d  = RLE_MODE;
    end
  end

  always_comb begin
    clk_en_d = (state_d == S_FILL) || (state_d == S_ARMED) ||
               (state_d == S_POST) || (state_d == S_FLUSH);
    busy_d   = clk_en_d;
    rle_en_d = rle_d && ((state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST));
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0; addr_q <= '0; trig_addr_q <= '0; trig_q <= 1'b0;
      pre_q <= '0; post_q <= '0; mask_q <= '0; val_q <= '0; rle_q <= 1'b0;
      clk_en_q <= 1'b0; rle_en_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; addr_q <= addr_d; trig_addr_q <= trig_addr_d; trig_q <= trig_d;
      pre_q <= pre_d; post_q <= post_d; mask_q <= mask_d; val_q <= val_d; rle_q <= rle_d;
      clk_en_q <= clk_en_d; rle_en_q <= rle_en_d; busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign CAP_CLK_EN = clk_en_q;
  assign CAP_RLE_EN = rle_en_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WE    = we;
  assign TRIG_ADDR  = trig_addr_q;
  assign BUSY       = busy_q;
  assign TRIGGERED  = trig_q;
  assign DONE       = done_q;
endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: completed captures are scored from a queue of
// hand-computed {trigger address, final address} pairs; control-state checks are inline.
module tb_la_capture_ctrl;
  localparam int AW = 4;

  logic          CLK = 1'b0, RESET = 1'b1, START = 1'b0, ABORT = 1'b0, RLE_MODE = 1'b0;
  logic          FORCE_TRIG = 1'b0, ADDR_CNT_EN = 1'b0;
  logic [7:0]    TRIG_MASK = 8'h00, TRIG_VALUE = 8'h00, LA_DATA = 8'h00;
  logic [AW-1:0] PRE_CNT = '0, POST_CNT = '0;
  logic          CAP_CLK_EN, CAP_RLE_EN, SRAM_WE, BUSY, TRIGGERED, DONE;
  logic [AW-1:0] SRAM_ADDR, TRIG_ADDR;

  la_capture_ctrl #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .RLE_MODE(RLE_MODE),
    .FORCE_TRIG(FORCE_TRIG), .TRIG_MASK(TRIG_MASK), .TRIG_VALUE(TRIG_VALUE),
    .PRE_CNT(PRE_CNT), .POST_CNT(POST_CNT), .LA_DATA(LA_DATA), .ADDR_CNT_EN(ADDR_CNT_EN),
    .CAP_CLK_EN(CAP_CLK_EN), .CAP_RLE_EN(CAP_RLE_EN), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE(SRAM_WE), .TRIG_ADDR(TRIG_ADDR), .BUSY(BUSY), .TRIGGERED(TRIGGERED), .DONE(DONE));

  always #5 CLK = ~CLK;

  typedef struct packed { logic [AW-1:0] ta; logic [AW-1:0] sa; } exp_t;
  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_cap(input logic rle, input logic [AW-1:0] pre, input logic [AW-1:0] post,
                           input logic [7:0] mask, input logic [7:0] val);
    RLE_MODE = rle; PRE_CNT = pre; POST_CNT = post; TRIG_MASK = mask; TRIG_VALUE = val;
    START = 1'b1; tick(); START = 1'b0;
    // scramble the live inputs; the capture must use the latched copies
    RLE_MODE = ~rle; PRE_CNT = ~pre; POST_CNT = ~post; TRIG_MASK = ~mask; TRIG_VALUE = ~val;
  endtask

  // one write per cycle; LA_DATA=A5 from write match_idx on, FORCE_TRIG at write force_idx
  task automatic cap(input string nm, input int match_idx, input int force_idx);
    bit seen = 0;
    ADDR_CNT_EN = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      LA_DATA    = (i >= match_idx) ? 8'hA5 : 8'h00;
      FORCE_TRIG = (i == force_idx);
      tick();
      seen = DONE;
    end
    ADDR_CNT_EN = 1'b0; FORCE_TRIG = 1'b0; LA_DATA = 8'h00;
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  // monitor: score every completed capture against the queue
  logic done_prev = 1'b0;
  always @(negedge CLK) begin
    if (DONE && !done_prev) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_trig_addr", TRIG_ADDR, e.ta);
        chk("done_sram_addr", SRAM_ADDR, e.sa);
        chk("done_triggered", TRIGGERED, 1);
        chk("done_clk_en", CAP_CLK_EN, 0);
        chk("done_busy", BUSY, 0);
      end
    end
    done_prev <= DONE;
  end

  initial begin
    tick(); tick(); RESET = 1'b0;
    chk("rst_state", {CAP_CLK_EN, CAP_RLE_EN, SRAM_WE, BUSY, TRIGGERED, DONE}, 0);
    chk("rst_addrs", {SRAM_ADDR, TRIG_ADDR}, 0);

    // 1: basic capture, trigger at write 5
    start_cap(1'b0, 4'd3, 4'd2, 8'hFF, 8'hA5);
    chk("t1_busy", BUSY, 1);
    sb.push_back('{ta: 4'd5, sa: 4'd8});
    cap("t1", 5, -1);

    // 2: pattern present during FILL is ignored until ARMED
    start_cap(1'b0, 4'd4, 4'd1, 8'hFF, 8'hA5);
    sb.push_back('{ta: 4'd4, sa: 4'd6});
    cap("t2", 0, -1);

    // 3: no match for 20 writes, forced trigger after address wrap
    start_cap(1'b0, 4'd2, 4'd2, 8'hFF, 8'hA5);
    sb.push_back('{ta: 4'd4, sa: 4'd7});
    cap("t3", 99, 20);

    // 4: RLE capture with flush
    start_cap(1'b1, 4'd1, 4'd1, 8'h00, 8'h00);
    chk("t4_rle_fill", CAP_RLE_EN, 1);
    ADDR_CNT_EN = 1'b1; tick();
    FORCE_TRIG = 1'b1; tick(); FORCE_TRIG = 1'b0;
    chk("t4_rle_post", CAP_RLE_EN, 1);
    tick();
    ADDR_CNT_EN = 1'b0; #1;
    chk("t4_flush_rle", CAP_RLE_EN, 0);
    chk("t4_flush_clk", {CAP_CLK_EN, BUSY, SRAM_WE}, 3'b110);
    tick();
    chk("t4_flush_wait", DONE, 0);
    sb.push_back('{ta: 4'd1, sa: 4'd4});
    ADDR_CNT_EN = 1'b1; #1;
    chk("t4_flush_we", SRAM_WE, 1);
    tick(); ADDR_CNT_EN = 1'b0;
    chk("t4_done", DONE, 1);

    // 5: ABORT beats START in ARMED
    start_cap(1'b0, 4'd1, 4'd3, 8'hFF, 8'hA5);
    ADDR_CNT_EN = 1'b1; tick(); ADDR_CNT_EN = 1'b0;
    ABORT = 1'b1; START = 1'b1; tick(); ABORT = 1'b0; START = 1'b0;
    chk("t5_abort", {BUSY, DONE, TRIGGERED, CAP_CLK_EN}, 0);
    chk("t5_addr_hold", SRAM_ADDR, 1);
    start_cap(1'b0, 4'd1, 4'd3, 8'hFF, 8'hA5);
    chk("t5_restart", {BUSY, SRAM_ADDR}, {1'b1, 4'd0});
    ABORT = 1'b1; tick(); ABORT = 1'b0;

    // 6: RESET in POST, then skipped FILL with mask 0 and forced trigger
    start_cap(1'b0, 4'd1, 4'd3, 8'hFF, 8'hA5);
    ADDR_CNT_EN = 1'b1; tick();
    FORCE_TRIG = 1'b1; tick(); FORCE_TRIG = 1'b0; tick();
    chk("t6_post", {TRIGGERED, BUSY, TRIG_ADDR}, {2'b11, 4'd1});
    RESET = 1'b1; tick(); RESET = 1'b0; ADDR_CNT_EN = 1'b0; #1;
    chk("t6_rst_flags", {CAP_CLK_EN, CAP_RLE_EN, SRAM_WE, BUSY, TRIGGERED, DONE}, 0);
    chk("t6_rst_addrs", {SRAM_ADDR, TRIG_ADDR}, 0);
    start_cap(1'b0, 4'd0, 4'd0, 8'h00, 8'hA5);
    LA_DATA = 8'hA5; tick(); tick(); tick();
    chk("t6_mask0", {TRIGGERED, BUSY}, 2'b01);
    sb.push_back('{ta: 4'd0, sa: 4'd0});
    FORCE_TRIG = 1'b1; tick(); FORCE_TRIG = 1'b0; LA_DATA = 8'h00;
    chk("t6_done", DONE, 1);

    tick(); tick();
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- Sequences one logic-analyzer capture around the RLE compressor and the sample SRAM.
- Gates the compressor clock-enable and RLE mode, and turns the compressor's address-count strobe into SRAM write strobes on a circular address.
- Fills a pre-trigger window, arms a masked pattern trigger, counts post-trigger writes, flushes the pending RLE run, then reports done with the trigger address.

Parameters:
ADDR_W, 16, SRAM address width; the buffer depth is 2^ADDR_W entries.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
START  in  1  one-cycle start pulse
ABORT  in  1  one-cycle abort pulse
RLE_MODE  in  1  1 = capture with RLE compression
FORCE_TRIG  in  1  software trigger
TRIG_MASK  in  8  bits that take part in the trigger compare
TRIG_VALUE  in  8  trigger pattern
PRE_CNT  in  ADDR_W  SRAM writes required before arming
POST_CNT  in  ADDR_W  SRAM writes after the trigger cycle
LA_DATA  in  8  aligned sample from the compressor data output
ADDR_CNT_EN  in  1  compressor address-count strobe
CAP_CLK_EN  out  1  compressor clock-enable
CAP_RLE_EN  out  1  compressor RLE enable
SRAM_ADDR  out  ADDR_W  current write address
SRAM_WE  out  1  SRAM write strobe
TRIG_ADDR  out  ADDR_W  address written in the trigger cycle
BUSY  out  1  capture in progress
TRIGGERED  out  1  trigger has occurred
DONE  out  1  capture complete

Behaviour:
- RESET: state IDLE; CAP_CLK_EN=0, CAP_RLE_EN=0, SRAM_ADDR=0, SRAM_WE=0, TRIG_ADDR=0, BUSY=0, TRIGGERED=0, DONE=0. RESET asserted mid-capture overrides everything in the same cycle.
- States: IDLE, FILL, ARMED, POST, FLUSH, DONE. All outputs are registered except SRAM_WE.
- SRAM_WE = ADDR_CNT_EN AND state in {FILL, ARMED, POST, FLUSH}. This is combinational and valid in the same cycle as the strobe.
- SRAM_ADDR increments by 1 after every SRAM_WE cycle. It wraps from 2^ADDR_W-1 to 0, so the buffer is circular.
- IDLE/DONE → FILL on START:
  - SRAM_ADDR←0, write counter←0, TRIGGERED←0, DONE←0.
  - PRE_CNT, POST_CNT, TRIG_MASK, TRIG_VALUE and RLE_MODE are latched at this edge. Later input changes have no effect until the next START.
- START in FILL, ARMED, POST or FLUSH is ignored.
- CAP_CLK_EN=1 in FILL, ARMED, POST and FLUSH; otherwise 0.
- CAP_RLE_EN = latched RLE_MODE in FILL, ARMED and POST; 0 otherwise, including FLUSH.
- BUSY=1 in every state except IDLE and DONE.
- FILL:
  - Counts SRAM_WE cycles.
  - Goes to ARMED when the count reaches the latched PRE_CNT, counting the write in the current cycle.
  - If PRE_CNT=0, goes to ARMED on the first cycle.
  - Trigger is ignored in FILL.
- ARMED:
  - match = (((LA_DATA ^ TRIG_VALUE) & TRIG_MASK) == 0) AND (TRIG_MASK != 0).
  - A mask of 0 never matches; only FORCE_TRIG fires.
  - On match OR FORCE_TRIG: TRIG_ADDR←SRAM_ADDR as it stands that cycle, before any increment; TRIGGERED←1; post counter←0; go to POST.
  - If POST_CNT=0, go directly to FLUSH (RLE mode) or DONE (RLE off).
  - A write in the trigger cycle belongs to ARMED.
- POST:
  - Counts SRAM_WE cycles.
  - When the count reaches POST_CNT, goes to FLUSH if RLE is on, else DONE.
- FLUSH:
  - CAP_RLE_EN=0 forces the compressor to emit the pending run.
  - Stays until the first ADDR_CNT_EN; that write is performed, then goes to DONE.
  - The compressor guarantees this write within 3 cycles.
- DONE:
  - DONE=1, BUSY=0, CAP_CLK_EN=0.
  - SRAM_ADDR holds the next write address; TRIG_ADDR and TRIGGERED hold.
  - Leaves only on START or RESET.
- ABORT in any BUSY state → IDLE:
  - CAP_CLK_EN=0, DONE=0, TRIGGERED=0.
  - SRAM_ADDR and TRIG_ADDR hold their values.
  - ABORT and START in the same cycle: ABORT wins.
- No overlap check: if PRE_CNT+POST_CNT ≥ depth, the buffer wraps and silently overwrites.

Test Plan:
1. ADDR_W=4, RLE_MODE=0, PRE_CNT=3, POST_CNT=2, mask=FF, value=A5; ADDR_CNT_EN held at 1; LA_DATA=A5 at the 6th write → FILL lasts 3 writes; trigger at write index 5 gives TRIG_ADDR=5; DONE after writes 6 and 7, with SRAM_ADDR=8 and CAP_CLK_EN=0.
2. Trigger pending (LA_DATA=A5, mask=FF, value=A5) during FILL with PRE_CNT=4 → no trigger until ARMED; TRIG_ADDR=4.
3. ADDR_W=4, pattern never matches for 20 writes, then FORCE_TRIG → SRAM_ADDR wraps 15→0 with no stall; TRIG_ADDR=4 (20 mod 16).
4. RLE_MODE=1, POST_CNT=1; after the post write → FLUSH drives CAP_RLE_EN=0; the next ADDR_CNT_EN produces SRAM_WE=1, then DONE=1.
5. ABORT in ARMED, with START in the same cycle → IDLE, BUSY=0, DONE=0; a later START restarts from SRAM_ADDR=0.
6. RESET asserted in POST → the next cycle shows every output at its reset value; PRE_CNT=0 and POST_CNT=0 with mask=00 and FORCE_TRIG → FILL is skipped, and DONE follows the forced trigger.
